// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave endpoint.
//   DATA_W_DEF  default transfer word width
//   spi_mode_e  SPI mode encoding {CPOL,CPHA}
//   cpol()/cpha() split a mode into clock polarity and clock phase
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_e;

  function automatic logic cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a toggle detector.
//   clk, rst_n  system clock, asynchronous active-low reset
//   din         asynchronous input pin
//   q           synchronised level
//   toggle      one-cycle pulse whenever q changes; q gives the direction
//               (toggle & q = rise, toggle & ~q = fall)
// RST_VAL is the level all flops take in reset, normally the pin's idle
// level, so that leaving reset does not produce a spurious edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic toggle
);

  logic meta;
  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      q_d  <= RST_VAL;
    end else begin
      meta <= din;
      q    <= meta;
      q_d  <= q;
    end
  end

  assign toggle = q ^ q_d;

endmodule

// File: rtl/spi_modport.sv
// SPI slave endpoint: full-duplex, word-oriented, MSB-first.
//   i_Clk, i_Rst_L          system clock, asynchronous active-low reset
//   o_RX_DV, o_RX_Byte      received word and its one-cycle valid pulse
//   i_TX_DV, i_TX_Byte      one-cycle load pulse and word to transmit
//   i_SPI_Clk, i_SPI_MOSI,
//   i_SPI_CS_n, o_SPI_MISO  SPI pins (asynchronous to i_Clk)
// Handshake: o_RX_DV and i_TX_DV are single-cycle valid strobes with no
// ready/back-pressure; the word is valid only in the cycle its strobe is high.
// All pins are oversampled; i_Clk must run at least 4x SCK.
import spi_pkg::*;

module spi_modport #(
  parameter int SPI_MODE = 0,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Byte,
  input  logic              i_TX_DV,
  input  logic [DATA_W-1:0] i_TX_Byte,
  input  logic              i_SPI_Clk,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO,
  input  logic              i_SPI_CS_n
);

  localparam spi_mode_e MODE  = spi_mode_e'(SPI_MODE[1:0]);
  localparam logic      CPOL  = cpol(MODE);
  localparam logic      CPHA  = cpha(MODE);
  localparam int        CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Pin synchronisation
  logic sck_q, sck_tog;
  logic cs_q, cs_tog;
  logic mosi_meta, mosi_q;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
    .clk    (i_Clk),
    .rst_n  (i_Rst_L),
    .din    (i_SPI_Clk),
    .q      (sck_q),
    .toggle (sck_tog)
  );

  // CS_n resets to "selected" so that a CS_n already low when reset is
  // released does not look like a fresh fall: a frame only opens on a real
  // high-to-low transition seen after reset.
  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk    (i_Clk),
    .rst_n  (i_Rst_L),
    .din    (i_SPI_CS_n),
    .q      (cs_q),
    .toggle (cs_tog)
  );

  // MOSI goes through the same two-flop delay as SCK, so the value seen
  // with an SCK edge pulse is the value present at the pin edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mosi_meta <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      mosi_meta <= i_SPI_MOSI;
      mosi_q    <= mosi_meta;
    end
  end

  // Edge classification: after a leading edge SCK sits away from its idle
  // level (CPOL); after a trailing edge it is back at idle.
  logic sck_lead, sck_trail, sample_edge, shift_edge, cs_fall;

  assign sck_lead    = sck_tog & (sck_q ^ CPOL);
  assign sck_trail   = sck_tog & ~(sck_q ^ CPOL);
  assign sample_edge = CPHA ? sck_trail : sck_lead;
  assign shift_edge  = CPHA ? sck_lead  : sck_trail;
  assign cs_fall     = cs_tog & ~cs_q;

  // Datapath
  logic              frame_active;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_next;

  assign rx_next = {rx_shift, mosi_q};
  // A load in the same cycle as a word start wins over the held value.
  assign tx_next = i_TX_DV ? i_TX_Byte : tx_hold;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      frame_active <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      tx_hold      <= '0;
      tx_shift     <= '0;
    end else begin
      o_RX_DV <= 1'b0;
      if (i_TX_DV) begin
        tx_hold <= i_TX_Byte;
      end

      if (cs_q) begin
        // Deselected: partial words are dropped and SCK is ignored.
        frame_active <= 1'b0;
        bit_cnt      <= '0;
      end else if (cs_fall) begin
        frame_active <= 1'b1;
        bit_cnt      <= '0;
        tx_shift     <= tx_next;
      end else if (frame_active) begin
        if (sample_edge) begin
          rx_shift <= rx_next[DATA_W-2:0];
          if (bit_cnt == LAST_BIT) begin
            o_RX_Byte <= rx_next;
            o_RX_DV   <= 1'b1;
            bit_cnt   <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // bit_cnt == 0 on a shift edge means a word boundary: with CPHA=0
        // the previous word has just been fully sampled, with CPHA=1 this is
        // the first edge of a new word. Either way the next word starts here.
        if (shift_edge) begin
          if (bit_cnt == '0) begin
            tx_shift <= tx_next;
          end else begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_SPI_MISO = frame_active ? tx_shift[DATA_W-1] : 1'b1;

endmodule

// File: tb/tb_spi_modport.sv
module tb_spi_modport;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Pins: SCK shared, one CS/MOSI/TX set per DUT (dut0 mode 0, dut1 mode 1)
  logic       sck     = 1'b0;
  logic       cs0_n   = 1'b1;
  logic       cs1_n   = 1'b1;
  logic       mosi0   = 1'b0;
  logic       mosi1   = 1'b0;
  logic       tx_dv0  = 1'b0;
  logic       tx_dv1  = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       miso0, miso1, rx_dv0, rx_dv1;
  logic [7:0] rx_byte0, rx_byte1;

  spi_modport #(.SPI_MODE(0), .DATA_W(8)) dut0 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .o_RX_DV    (rx_dv0),
    .o_RX_Byte  (rx_byte0),
    .i_TX_DV    (tx_dv0),
    .i_TX_Byte  (tx_byte),
    .i_SPI_Clk  (sck),
    .i_SPI_MOSI (mosi0),
    .o_SPI_MISO (miso0),
    .i_SPI_CS_n (cs0_n)
  );

  spi_modport #(.SPI_MODE(1), .DATA_W(8)) dut1 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .o_RX_DV    (rx_dv1),
    .o_RX_Byte  (rx_byte1),
    .i_TX_DV    (tx_dv1),
    .i_TX_Byte  (tx_byte),
    .i_SPI_Clk  (sck),
    .i_SPI_MOSI (mosi1),
    .o_SPI_MISO (miso1),
    .i_SPI_CS_n (cs1_n)
  );

  // Scoreboard
  int         n_checks = 0;
  int         n_pass   = 0;
  int         rx_cnt0  = 0;
  int         rx_cnt1  = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic monitor(input int mode);
    logic       prev = 1'b0;
    logic       dv;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      dv = (mode == 0) ? rx_dv0 : rx_dv1;
      b  = (mode == 0) ? rx_byte0 : rx_byte1;
      if (dv) begin
        check($sformatf("rx_dv_single_m%0d", mode), 8'(prev), 8'h00);
        if (mode == 0) rx_cnt0++; else rx_cnt1++;
        if ((mode == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected_m%0d: got word 0x%02h, expected no pulse", mode, b);
        end else if (mode == 0) begin
          check("rx_word_m0", b, exp_q0.pop_front());
        end else begin
          check("rx_word_m1", b, exp_q1.pop_front());
        end
      end
      prev = dv;
    end
  endtask

  // Driver tasks; every pin change lands on a falling i_Clk edge
  task automatic cs_set(input int mode, input logic v);
    @(negedge clk);
    if (mode == 0) cs0_n = v; else cs1_n = v;
    repeat (6) @(negedge clk);
  endtask

  task automatic tx_load(input int mode, input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    if (mode == 0) tx_dv0 = 1'b1; else tx_dv1 = 1'b1;
    @(negedge clk);
    tx_dv0 = 1'b0;
    tx_dv1 = 1'b0;
  endtask

  // Master side: mode 0 drives MOSI with SCK low and samples MISO on the
  // rise; mode 1 drives MOSI on the rise and samples MISO on the fall.
  task automatic spi_bits(input int mode, input int nbits, input logic [7:0] txw,
                          output logic [7:0] rxw);
    rxw = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (mode == 0) begin
        mosi0 = txw[7-i];
        #50 sck = 1'b1;
        rxw = {rxw[6:0], miso0};
        #50 sck = 1'b0;
      end else begin
        sck   = 1'b1;
        mosi1 = txw[7-i];
        #50 rxw = {rxw[6:0], miso1};
        sck = 1'b0;
        #50;
      end
    end
  endtask

  task automatic spi_byte(input int mode, input logic [7:0] mosi_w,
                          input logic [7:0] exp_miso, input string name);
    logic [7:0] got;
    if (mode == 0) exp_q0.push_back(mosi_w); else exp_q1.push_back(mosi_w);
    spi_bits(mode, 8, mosi_w, got);
    check(name, got, exp_miso);
  endtask

  task automatic check_idle_miso(input int mode, input string name);
    check(name, 8'((mode == 0) ? miso0 : miso1), 8'h01);
  endtask

  // Stimulus table: one single-word frame per record
  typedef struct {
    int         mode;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] junk;
  int         cnt_before;

  initial begin
    vecs[0] = '{0, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{0, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{0, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{1, 8'hC3, 8'hC3, 8'hC3};
    vecs[4] = '{1, 8'h5A, 8'h96, 8'h5A};
    vecs[5] = '{1, 8'h01, 8'h80, 8'h01};

    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rx_dv0",   8'(rx_dv0), 8'h00);
    check("reset_rx_byte0", rx_byte0,   8'h00);
    check("reset_miso0",    8'(miso0),  8'h01);
    check("reset_rx_dv1",   8'(rx_dv1), 8'h00);
    check("reset_rx_byte1", rx_byte1,   8'h00);
    check("reset_miso1",    8'(miso1),  8'h01);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single-word frames
    for (int i = 0; i < 6; i++) begin
      tx_load(vecs[i].mode, vecs[i].tx);
      cs_set(vecs[i].mode, 1'b0);
      spi_byte(vecs[i].mode, vecs[i].mosi, vecs[i].exp_miso, $sformatf("vec%0d_miso", i));
      cs_set(vecs[i].mode, 1'b1);
      check_idle_miso(vecs[i].mode, $sformatf("vec%0d_miso_idle", i));
    end

    // Random frames in both modes
    for (int i = 0; i < 8; i++) begin
      int         m;
      logic [7:0] t, d;
      m = i % 2;
      t = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      tx_load(m, t);
      cs_set(m, 1'b0);
      spi_byte(m, d, t, $sformatf("rand%0d_miso", i));
      cs_set(m, 1'b1);
    end

    // Back-to-back words in one frame; third word has no new load and resends
    tx_load(0, 8'h81);
    cs_set(0, 1'b0);
    tx_load(0, 8'h7E);
    spi_byte(0, 8'h01, 8'h81, "b2b_w0_miso");
    spi_byte(0, 8'hFF, 8'h7E, "b2b_w1_miso");
    spi_byte(0, 8'h33, 8'h7E, "b2b_resend_miso");
    cs_set(0, 1'b1);
    check_idle_miso(0, "b2b_miso_idle");

    // CS_n released after 5 bits: no word, then a clean frame
    cnt_before = rx_cnt0;
    tx_load(0, 8'hE7);
    cs_set(0, 1'b0);
    spi_bits(0, 5, 8'hFF, junk);
    cs_set(0, 1'b1);
    repeat (10) @(negedge clk);
    check("abort_no_rx", 8'(rx_cnt0 - cnt_before), 8'h00);
    cs_set(0, 1'b0);
    spi_byte(0, 8'h5A, 8'hE7, "after_abort_miso");
    cs_set(0, 1'b1);

    // Reset mid-word
    tx_load(0, 8'h6B);
    cs_set(0, 1'b0);
    spi_bits(0, 4, 8'h96, junk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rx_dv0",   8'(rx_dv0), 8'h00);
    check("midrst_rx_byte0", rx_byte0,   8'h00);
    check("midrst_miso0",    8'(miso0),  8'h01);
    check("midrst_rx_byte1", rx_byte1,   8'h00);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_resume_miso0", 8'(miso0), 8'h01);
    cs_set(0, 1'b1);
    cs_set(0, 1'b0);
    spi_byte(0, 8'h96, 8'h00, "after_rst_miso");
    cs_set(0, 1'b1);

    // Drain: every pushed word must have come out
    repeat (20) @(negedge clk);
    check("rx_pending_m0", 8'(exp_q0.size()), 8'h00);
    check("rx_pending_m1", 8'(exp_q1.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
